// File: rtl/regfile_primitives.sv
// regfile_primitives -- three independent register-file building blocks.
//
//   * Bit register: a one-bit storage cell. It has a load enable, an
//     asynchronous active-low clear (RST) and an asynchronous active-low
//     preset (SN). When both are asserted together, the clear wins.
//   * 5-to-32 decoder: turns a binary address into a one-hot row select.
//   * 32-bit 2:1 mux: a plain ternary mux. In a four-state simulator it
//     passes Z through from the selected input, and with an unknown select
//     it gives X wherever the two inputs disagree.
//
// The three functions share no logic or state. Only the bit register is
// clocked.
//
// Ports
//   CLK      in   1   clock, rising edge
//   RST      in   1   asynchronous active-low clear of the bit register
//   SN       in   1   asynchronous active-low preset of the bit register
//   L        in   1   bit-register load enable
//   D        in   1   bit-register data in
//   Q        out  1   bit-register stored value
//   QB       out  1   complement of Q
//   DEC_SEL  in   5   decoder binary select
//   DEC_OUT  out  32  decoder one-hot output
//   MUX_I0   in   32  mux input used when MUX_S = 0
//   MUX_I1   in   32  mux input used when MUX_S = 1
//   MUX_S    in   1   mux select
//   MUX_Y    out  32  mux output
module regfile_primitives (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SN,
  input  logic        L,
  input  logic        D,
  output logic        Q,
  output logic        QB,
  input  logic [4:0]  DEC_SEL,
  output logic [31:0] DEC_OUT,
  input  logic [31:0] MUX_I0,
  input  logic [31:0] MUX_I1,
  input  logic        MUX_S,
  output logic [31:0] MUX_Y
);

  logic q_reg;

  // The clear is tested before the preset, so the clear wins when both are
  // low. The asynchronous controls only act on their falling edges.
  // Releasing either one therefore leaves q_reg unchanged until the next
  // loading clock edge.
  always_ff @(posedge CLK or negedge RST or negedge SN) begin
    if (!RST) begin
      q_reg <= 1'b0;
    end else if (!SN) begin
      q_reg <= 1'b1;
    end else if (L) begin
      q_reg <= D;
    end
  end

  // QB is derived from the same flop as Q. This keeps QB the exact
  // complement of Q, including while the clear or preset is held.
  assign Q  = q_reg;
  assign QB = ~q_reg;

  // Each decoder output bit compares DEC_SEL with its own index.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_dec
      assign DEC_OUT[gi] = (DEC_SEL == 5'(gi));
    end
  endgenerate

  // This is deliberately a continuous ternary. In a four-state simulator
  // it passes Z straight through from the selected input. With an unknown
  // select, bits where the inputs agree keep that value and the other bits
  // become X.
  assign MUX_Y = MUX_S ? MUX_I1 : MUX_I0;

endmodule

// File: tb/tb_regfile_primitives.sv
module tb_regfile_primitives;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SN;
  logic        L;
  logic        D;
  logic        Q;
  logic        QB;
  logic [4:0]  DEC_SEL;
  logic [31:0] DEC_OUT;
  logic [31:0] MUX_I0;
  logic [31:0] MUX_I1;
  logic        MUX_S;
  logic [31:0] MUX_Y;

  int passed = 0;
  int total  = 0;
  bit four_state;

  regfile_primitives dut (
    .CLK(CLK), .RST(RST), .SN(SN), .L(L), .D(D), .Q(Q), .QB(QB),
    .DEC_SEL(DEC_SEL), .DEC_OUT(DEC_OUT),
    .MUX_I0(MUX_I0), .MUX_I1(MUX_I1), .MUX_S(MUX_S), .MUX_Y(MUX_Y)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    // Hold the clear low with D=1 and L=1 while the clock keeps running.
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      total++;
      if ({Q, QB} !== 2'b01) $display("FAIL reset_hold edge%0d: Q/QB=%b expected 01", k, {Q, QB});
      else passed++;
    end
    @(negedge CLK); RST = 1'b1;
    #1;
    total++;
    if ({Q, QB} !== 2'b01) $display("FAIL reset_release: Q/QB=%b expected 01", {Q, QB});
    else passed++;
    @(posedge CLK); #1;
    total++;
    if ({Q, QB} !== 2'b10) $display("FAIL first_load: Q/QB=%b expected 10", {Q, QB});
    else passed++;
    $display("test_reset: Q=%b QB=%b", Q, QB);
  endtask

  task automatic test_load_hold();
    @(negedge CLK); L = 1'b0; D = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      total++;
      if (Q !== 1'b1) $display("FAIL hold edge%0d: Q=%b expected 1", k, Q);
      else passed++;
    end
    @(negedge CLK); L = 1'b1;
    @(posedge CLK); #1;
    total++;
    if ({Q, QB} !== 2'b01) $display("FAIL load0: Q/QB=%b expected 01", {Q, QB});
    else passed++;
    // Change D between edges. Q must not move until the next edge.
    #2 D = 1'b1;
    #1;
    total++;
    if (Q !== 1'b0) $display("FAIL mid_cycle_D: Q=%b expected 0", Q);
    else passed++;
    @(posedge CLK); #1;
    total++;
    if (Q !== 1'b1) $display("FAIL load1: Q=%b expected 1", Q);
    else passed++;
    $display("test_load_hold: Q=%b", Q);
  endtask

  task automatic test_preset();
    @(negedge CLK); L = 1'b1; D = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK); L = 1'b0;
    #1 SN = 1'b0;
    #1;
    total++;
    if ({Q, QB} !== 2'b10) $display("FAIL preset: Q/QB=%b expected 10", {Q, QB});
    else passed++;
    RST = 1'b0;
    #1;
    total++;
    if ({Q, QB} !== 2'b01) $display("FAIL reset_over_preset: Q/QB=%b expected 01", {Q, QB});
    else passed++;
    // Release both controls between edges. Q stays at its cleared value.
    RST = 1'b1;
    #1 SN = 1'b1;
    #1;
    total++;
    if (Q !== 1'b0) $display("FAIL release_both: Q=%b expected 0", Q);
    else passed++;
    $display("test_preset: Q=%b QB=%b", Q, QB);
  endtask

  task automatic test_mid_reset();
    @(negedge CLK); L = 1'b1; D = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (Q !== 1'b1) $display("FAIL pre_mid_reset_load: Q=%b expected 1", Q);
    else passed++;
    // Assert the clear while CLK is high.
    #1 RST = 1'b0;
    #1;
    total++;
    if ({Q, QB} !== 2'b01) $display("FAIL mid_reset: Q/QB=%b expected 01", {Q, QB});
    else passed++;
    @(posedge CLK); #1;
    total++;
    if (Q !== 1'b0) $display("FAIL load_blocked: Q=%b expected 0", Q);
    else passed++;
    @(negedge CLK); RST = 1'b1;
    $display("test_mid_reset: Q=%b", Q);
  endtask

  task automatic test_decoder();
    logic [31:0] exp;
    for (int i = 0; i < 32; i++) begin
      DEC_SEL = 5'(i);
      exp = 32'h1 << i;
      #1;
      total++;
      if (DEC_OUT !== exp) $display("FAIL dec_sel%0d: DEC_OUT=%h expected %h", i, DEC_OUT, exp);
      else passed++;
    end
    $display("test_decoder: swept 0..31, last DEC_OUT=%h", DEC_OUT);
  endtask

  task automatic test_mux();
    MUX_I0 = 32'h12345678; MUX_I1 = 32'h9ABCDEF0;
    MUX_S = 1'b0; #1;
    total++;
    if (MUX_Y !== 32'h12345678) $display("FAIL mux_s0: MUX_Y=%h expected 12345678", MUX_Y);
    else passed++;
    MUX_S = 1'b1; #1;
    total++;
    if (MUX_Y !== 32'h9ABCDEF0) $display("FAIL mux_s1: MUX_Y=%h expected 9abcdef0", MUX_Y);
    else passed++;
    MUX_I1 = 32'hFFFF0000; #1;
    total++;
    if (MUX_Y !== 32'hFFFF0000) $display("FAIL mux_follow: MUX_Y=%h expected ffff0000", MUX_Y);
    else passed++;
    $display("test_mux: MUX_Y=%h", MUX_Y);
  endtask

  task automatic test_mux_z();
    MUX_I0 = 32'hZZZZZZZZ; MUX_I1 = 32'hA5A5A5A5;
    MUX_S = 1'b1; #1;
    total++;
    if (MUX_Y !== 32'hA5A5A5A5) $display("FAIL mux_z_s1: MUX_Y=%h expected a5a5a5a5", MUX_Y);
    else passed++;
    MUX_S = 1'b0; #1;
    // A Z value can only be observed when the simulator is four-state.
    if (four_state) begin
      total++;
      if (MUX_Y !== 32'hZZZZZZZZ) $display("FAIL mux_z_s0: MUX_Y=%h expected zzzzzzzz", MUX_Y);
      else passed++;
    end
    $display("test_mux_z: MUX_Y=%h", MUX_Y);
  endtask

  task automatic test_mux_x();
    MUX_I0 = 32'h0000FFFF; MUX_I1 = 32'h00FF00FF;
    MUX_S = 1'bx; #1;
    // Bits where the two inputs agree must be known, whatever the select.
    total++;
    if ((MUX_Y & 32'hFF0000FF) !== 32'h000000FF)
      $display("FAIL mux_x_agree: MUX_Y=%h expected 00xxxxff", MUX_Y);
    else passed++;
    if (four_state) begin
      total++;
      if (MUX_Y !== 32'b00000000_xxxxxxxx_xxxxxxxx_11111111)
        $display("FAIL mux_x_full: MUX_Y=%b expected 00000000xxxxxxxxxxxxxxxx11111111", MUX_Y);
      else passed++;
    end
    $display("test_mux_x: MUX_Y=%h", MUX_Y);
  endtask

  task automatic test_independence();
    DEC_SEL = 5'd7; MUX_I0 = 32'hCAFEF00D; MUX_I1 = 32'h0BADBEEF; MUX_S = 1'b1;
    @(negedge CLK); RST = 1'b0; SN = 1'b0; L = 1'b1; D = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (DEC_OUT !== 32'h00000080 || MUX_Y !== 32'h0BADBEEF)
      $display("FAIL independence_ctl: DEC_OUT=%h MUX_Y=%h expected 00000080 0badbeef", DEC_OUT, MUX_Y);
    else passed++;
    @(negedge CLK); RST = 1'b1; SN = 1'b1;
    // Switching the mux select must not disturb the bit register.
    MUX_S = 1'b0; DEC_SEL = 5'd0; #1;
    total++;
    if ({Q, QB} !== 2'b01 || MUX_Y !== 32'hCAFEF00D || DEC_OUT !== 32'h1)
      $display("FAIL independence_io: Q/QB=%b MUX_Y=%h DEC_OUT=%h expected 01 cafef00d 00000001",
               {Q, QB}, MUX_Y, DEC_OUT);
    else passed++;
    $display("test_independence: Q=%b DEC_OUT=%h MUX_Y=%h", Q, DEC_OUT, MUX_Y);
  endtask

  initial begin
    logic probe;
    probe = 1'bx;
    four_state = $isunknown(probe);
    RST = 1'b0; SN = 1'b1; L = 1'b1; D = 1'b1;
    DEC_SEL = 5'd0; MUX_I0 = '0; MUX_I1 = '0; MUX_S = 1'b0;
    #1;
    total++;
    if ({Q, QB} !== 2'b01) $display("FAIL reset_state: Q/QB=%b expected 01", {Q, QB});
    else passed++;
    test_reset();
    test_load_hold();
    test_preset();
    test_mid_reset();
    test_decoder();
    test_mux();
    test_mux_z();
    test_mux_x();
    test_independence();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
